// File: rtl/vic_timing_pkg.sv
// rtl/vic_timing_pkg.sv - chip codes, sync FSM encodings and per-chip timing constants
// Purpose: types and constants shared by the sync sequencer and its timing LUT.
// Ports: none (package).
package vic_timing_pkg;

  // Chip codes; bit0 set marks a PAL part.
  localparam logic [1:0] CHIP6567R8   = 2'd0;
  localparam logic [1:0] CHIP6569R1   = 2'd1;
  localparam logic [1:0] CHIP6567R56A = 2'd2;
  localparam logic [1:0] CHIP6569R5   = 2'd3;

  typedef enum logic [2:0] {
    H_FPORCH = 3'd0,
    H_SYNC   = 3'd1,
    H_BREEZE = 3'd2,
    H_BURST  = 3'd3,
    H_BPORCH = 3'd4,
    H_ACTIVE = 3'd5
  } hstate_t;

  typedef enum logic [2:0] {
    V_ACTIVE = 3'd0,
    V_PRE    = 3'd1,
    V_EQ1    = 3'd2,
    V_SERR   = 3'd3,
    V_EQ2    = 3'd4,
    V_POST   = 3'd5
  } vstate_t;

  typedef enum logic [1:0] {
    VMODE_NORMAL = 2'd0,
    VMODE_EQ     = 2'd1,
    VMODE_SERR   = 2'd2
  } vmode_t;

  // Horizontal boundaries in raster_x units, vertical in raster_y lines.
  localparam logic [9:0] NTSC_HSYNC_START  = 10'd8;
  localparam logic [9:0] NTSC_HSYNC_END    = 10'd45;
  localparam logic [9:0] NTSC_BURST_START  = 10'd50;
  localparam logic [9:0] NTSC_BURST_LEN    = 10'd21;
  localparam logic [9:0] NTSC_HVIS_START   = 10'd96;
  localparam logic [8:0] NTSC_VBLANK_START = 9'd14;

  localparam logic [9:0] PAL_HSYNC_START   = 10'd7;
  localparam logic [9:0] PAL_HSYNC_END     = 10'd44;
  localparam logic [9:0] PAL_BURST_START   = 10'd49;
  localparam logic [9:0] PAL_BURST_LEN     = 10'd16;
  localparam logic [9:0] PAL_HVIS_START    = 10'd91;
  localparam logic [8:0] PAL_VBLANK_START  = 9'd301;

  typedef struct packed {
    logic [9:0] hsync_start;
    logic [9:0] hsync_end;
    logic [9:0] burst_start;
    logic [9:0] burst_end;     // first x after the burst window
    logic [9:0] hvis_start;
    logic [8:0] vblank_start;
  } timing_t;

  // Horizontal state whose interval contains x.
  function automatic hstate_t h_region(input logic [9:0] x, input timing_t t);
    hstate_t r;
    if (x < t.hsync_start)      r = H_FPORCH;
    else if (x < t.hsync_end)   r = H_SYNC;
    else if (x < t.burst_start) r = H_BREEZE;
    else if (x < t.burst_end)   r = H_BURST;
    else if (x < t.hvis_start)  r = H_BPORCH;
    else                        r = H_ACTIVE;
    return r;
  endfunction

  function automatic vmode_t vmode_of(input vstate_t v);
    vmode_t r;
    case (v)
      V_EQ1, V_EQ2: r = VMODE_EQ;
      V_SERR:       r = VMODE_SERR;
      default:      r = VMODE_NORMAL;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sync_sequencer_if.sv
// rtl/sync_sequencer_if.sv - raster inputs and sync outputs of the sync sequencer
// Purpose: bundles the raster position/chip inputs and the registered sync outputs.
// Signals: chip, raster_x, raster_y (master -> slave);
//          hsync, blank, burst_gate, burst_odd, vmode, line_start, hstate (slave -> master).
interface sync_sequencer_if;
  logic [1:0] chip;
  logic [9:0] raster_x;
  logic [8:0] raster_y;
  logic       hsync;
  logic       blank;
  logic       burst_gate;
  logic       burst_odd;
  logic [1:0] vmode;
  logic       line_start;
  logic [2:0] hstate;

  modport master (
    output chip, raster_x, raster_y,
    input  hsync, blank, burst_gate, burst_odd, vmode, line_start, hstate
  );

  modport slave (
    input  chip, raster_x, raster_y,
    output hsync, blank, burst_gate, burst_odd, vmode, line_start, hstate
  );
endinterface

// File: rtl/sync_timing_lut.sv
// rtl/sync_timing_lut.sv - combinational map from chip code to sync boundary constants
// Purpose: selects NTSC or PAL horizontal/vertical boundaries for the latched chip.
// Ports: chip (in, 2) latched chip code; timing (out) boundary set.
module sync_timing_lut
  import vic_timing_pkg::*;
(
  input  logic [1:0] chip,
  output timing_t    timing
);

  localparam timing_t NTSC_TIMING = '{
    hsync_start:  NTSC_HSYNC_START,
    hsync_end:    NTSC_HSYNC_END,
    burst_start:  NTSC_BURST_START,
    burst_end:    NTSC_BURST_START + NTSC_BURST_LEN,
    hvis_start:   NTSC_HVIS_START,
    vblank_start: NTSC_VBLANK_START
  };

  localparam timing_t PAL_TIMING = '{
    hsync_start:  PAL_HSYNC_START,
    hsync_end:    PAL_HSYNC_END,
    burst_start:  PAL_BURST_START,
    burst_end:    PAL_BURST_START + PAL_BURST_LEN,
    hvis_start:   PAL_HVIS_START,
    vblank_start: PAL_VBLANK_START
  };

  always_comb begin
    case (chip)
      CHIP6567R8, CHIP6567R56A: timing = NTSC_TIMING;
      CHIP6569R1, CHIP6569R5:   timing = PAL_TIMING;
      default:                  timing = NTSC_TIMING;
    endcase
  end

endmodule

// File: rtl/sync_sequencer.sv
// rtl/sync_sequencer.sv - horizontal/vertical sync sequencer driven by the raster position
// Purpose: derives hsync, blanking, colour-burst gate and vertical line type from
//          raster_x/raster_y; all outputs registered, one clk_dot4x after the sample.
// Ports: clk_dot4x (in) clock; rst (in) synchronous active-high reset;
//        bus (sync_sequencer_if.slave) raster/chip inputs and sync outputs.
module sync_sequencer
  import vic_timing_pkg::*;
(
  input  logic            clk_dot4x,
  input  logic            rst,
  sync_sequencer_if.slave bus
);

  logic [1:0] chip_q;
  logic [9:0] prev_x_q;
  hstate_t    hstate_q, hstate_d, x_region;
  vstate_t    vstate_q, vstate_d;
  logic [1:0] line_cnt_q, line_cnt_d;
  logic       hsync_q, hsync_d;
  logic       blank_q, blank_d;
  logic       burst_gate_q, burst_gate_d;
  logic       burst_odd_q, burst_odd_d;
  logic       line_start_q;
  vmode_t     vmode_q, vmode_d;

  timing_t    timing;
  logic       ls_det;
  logic       chip_load;
  logic       chip_change;
  logic [8:0] vvisible_end;

  sync_timing_lut u_lut (
    .chip   (chip_q),
    .timing (timing)
  );

  always_comb begin : line_detect
    ls_det       = (bus.raster_x == 10'd0) && (prev_x_q != 10'd0);
    // The chip code only changes at a frame boundary so a frame never mixes timings.
    chip_load    = ls_det && (bus.raster_y == 9'd0);
    chip_change  = chip_load && (bus.chip != chip_q);
    vvisible_end = timing.vblank_start - 9'd1;
  end

  // Each state leaves once x reaches its end boundary and lands in whichever
  // state holds x, so a jump over several boundaries never leaves a stale state.
  always_comb begin : hfsm_next
    x_region = h_region(bus.raster_x, timing);
    hstate_d = hstate_q;
    if (ls_det) begin
      hstate_d = H_FPORCH;
    end else begin
      case (hstate_q)
        H_FPORCH: if (bus.raster_x >= timing.hsync_start) hstate_d = x_region;
        H_SYNC:   if (bus.raster_x >= timing.hsync_end)   hstate_d = x_region;
        H_BREEZE: if (bus.raster_x >= timing.burst_start) hstate_d = x_region;
        H_BURST:  if (bus.raster_x >= timing.burst_end)   hstate_d = x_region;
        H_BPORCH: if (bus.raster_x >= timing.hvis_start)  hstate_d = x_region;
        H_ACTIVE: hstate_d = H_ACTIVE;
        default:  hstate_d = x_region;
      endcase
    end
  end

  // Vertical sequence counts lines from the pre-equalization line; the 2-bit
  // counter runs 0..2 inside each three-line EQ/serration group.
  always_comb begin : vfsm_next
    vstate_d   = vstate_q;
    line_cnt_d = line_cnt_q;
    if (chip_change) begin
      vstate_d   = V_ACTIVE;
      line_cnt_d = 2'd0;
    end else if (ls_det) begin
      case (vstate_q)
        V_ACTIVE: begin
          if (bus.raster_y == vvisible_end) vstate_d = V_PRE;
        end
        V_PRE: begin
          vstate_d   = V_EQ1;
          line_cnt_d = 2'd0;
        end
        V_EQ1, V_SERR, V_EQ2: begin
          if (line_cnt_q == 2'd2) begin
            line_cnt_d = 2'd0;
            case (vstate_q)
              V_EQ1:   vstate_d = V_SERR;
              V_SERR:  vstate_d = V_EQ2;
              default: vstate_d = V_POST;
            endcase
          end else begin
            line_cnt_d = line_cnt_q + 2'd1;
          end
        end
        V_POST: vstate_d = V_ACTIVE;
        default: begin
          vstate_d   = V_ACTIVE;
          line_cnt_d = 2'd0;
        end
      endcase
    end
  end

  // Outputs are decoded from next-state so they appear one cycle after the sample.
  always_comb begin : outputs_next
    vmode_d      = vmode_of(vstate_d);
    hsync_d      = (hstate_d == H_SYNC) && (vmode_d == VMODE_NORMAL);
    burst_gate_d = (hstate_d == H_BURST) && (vmode_d == VMODE_NORMAL);
    blank_d      = !((hstate_d == H_ACTIVE) && (vstate_d == V_ACTIVE));
    burst_odd_d  = ls_det ? bus.raster_y[0] : burst_odd_q;
  end

  always_ff @(posedge clk_dot4x) begin
    // Tracked through reset so a line start is detected right after release.
    prev_x_q <= bus.raster_x;
    if (rst) begin
      chip_q       <= bus.chip;
      hstate_q     <= H_FPORCH;
      vstate_q     <= V_ACTIVE;
      line_cnt_q   <= 2'd0;
      hsync_q      <= 1'b0;
      blank_q      <= 1'b1;
      burst_gate_q <= 1'b0;
      burst_odd_q  <= 1'b0;
      vmode_q      <= VMODE_NORMAL;
      line_start_q <= 1'b0;
    end else begin
      if (chip_load) chip_q <= bus.chip;
      hstate_q     <= hstate_d;
      vstate_q     <= vstate_d;
      line_cnt_q   <= line_cnt_d;
      hsync_q      <= hsync_d;
      blank_q      <= blank_d;
      burst_gate_q <= burst_gate_d;
      burst_odd_q  <= burst_odd_d;
      vmode_q      <= vmode_d;
      line_start_q <= ls_det;
    end
  end

  assign bus.hsync      = hsync_q;
  assign bus.blank      = blank_q;
  assign bus.burst_gate = burst_gate_q;
  assign bus.burst_odd  = burst_odd_q;
  assign bus.vmode      = vmode_q;
  assign bus.line_start = line_start_q;
  assign bus.hstate     = hstate_q;

endmodule

// File: tb/tb_sync_sequencer.sv
// tb/tb_sync_sequencer.sv - scoreboard testbench for sync_sequencer
module tb_sync_sequencer;

  logic clk_dot4x = 1'b0;
  logic rst = 1'b1;
  always #5 clk_dot4x = ~clk_dot4x;

  sync_sequencer_if bus ();

  sync_sequencer dut (
    .clk_dot4x (clk_dot4x),
    .rst       (rst),
    .bus       (bus)
  );

  localparam logic [1:0] NTSC = 2'd0;
  localparam logic [1:0] PAL  = 2'd1;

  typedef struct packed {
    logic       hsync;
    logic       blank;
    logic       burst_gate;
    logic       burst_odd;
    logic [1:0] vmode;
    logic       line_start;
    logic [2:0] hstate;
  } obs_t;

  typedef struct {
    obs_t exp;
    int   x;
    int   y;
  } sb_entry_t;

  sb_entry_t sb[$];
  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [1:0] m_chip  = 2'd0;
  int         m_prev  = 0;
  bit         m_valid = 1'b0;
  logic       m_odd   = 1'b0;

  int xs[18] = '{0, 5, 7, 8, 30, 44, 45, 49, 50, 60, 65, 70, 71, 91, 95, 96, 200, 500};
  int line_vm[512];
  bit line_hs[512];
  bit line_bg[512];

  sb_entry_t mon_e;
  obs_t      mon_got;

  always @(posedge clk_dot4x) begin
    #1;
    if (sb.size() != 0) begin
      mon_e   = sb.pop_front();
      mon_got = {bus.hsync, bus.blank, bus.burst_gate, bus.burst_odd, bus.vmode, bus.line_start, bus.hstate};
      n_checks++;
      if (mon_got !== mon_e.exp)
        $display("FAIL scoreboard x=%0d y=%0d hs/bl/bg/odd/vm/ls/h got=%b exp=%b",
                 mon_e.x, mon_e.y, mon_got, mon_e.exp);
      else
        n_pass++;
    end
  end

  task automatic drive(input logic r, input logic [1:0] c, input int x, input int y);
    sb_entry_t e;
    bit   ls;
    bit   vis;
    int   hs, he, bs, be, hv, vb, hreg, vm;
    @(negedge clk_dot4x);
    rst          = r;
    bus.chip     = c;
    bus.raster_x = 10'(x);
    bus.raster_y = 9'(y);
    if (r) begin
      m_chip  = c;
      m_valid = 1'b0;
      m_odd   = 1'b0;
      m_prev  = x;
      e.exp   = {1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0};
    end else begin
      ls     = (x == 0) && (m_prev != 0);
      m_prev = x;
      if (ls && y == 0) m_chip = c;
      if (m_chip == 2'd1 || m_chip == 2'd3) begin
        hs = 7; he = 44; bs = 49; be = 65; hv = 91; vb = 301;
      end else begin
        hs = 8; he = 45; bs = 50; be = 71; hv = 96; vb = 14;
      end
      if (ls) m_odd = ((y % 2) == 1);
      if (ls && y == vb - 1) m_valid = 1'b1;
      vis = 1'b1;
      vm  = 0;
      if (m_valid) begin
        if (y == vb - 1 || y == vb + 9) vis = 1'b0;
        else if (y >= vb && y <= vb + 8) begin
          vis = 1'b0;
          vm  = (y >= vb + 3 && y <= vb + 5) ? 2 : 1;
        end
      end
      if (x < hs) hreg = 0;
      else if (x < he) hreg = 1;
      else if (x < bs) hreg = 2;
      else if (x < be) hreg = 3;
      else if (x < hv) hreg = 4;
      else hreg = 5;
      e.exp.hsync      = (hreg == 1) && (vm == 0);
      e.exp.blank      = !((hreg == 5) && vis);
      e.exp.burst_gate = (hreg == 3) && (vm == 0);
      e.exp.burst_odd  = m_odd;
      e.exp.vmode      = 2'(vm);
      e.exp.line_start = ls;
      e.exp.hstate     = 3'(hreg);
    end
    e.x = x;
    e.y = y;
    sb.push_back(e);
    @(posedge clk_dot4x);
    #2;
  endtask

  task automatic sweep_lines(input logic [1:0] c, input int y0, input int y1);
    for (int y = y0; y <= y1; y++) begin
      line_vm[y] = -1;
      line_hs[y] = 1'b0;
      line_bg[y] = 1'b0;
      for (int i = 0; i < 18; i++) begin
        drive(1'b0, c, xs[i], y);
        line_hs[y] = line_hs[y] | bus.hsync;
        line_bg[y] = line_bg[y] | bus.burst_gate;
        if (xs[i] == 60) line_vm[y] = int'(bus.vmode);
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) drive(1'b1, PAL, 0, 0);
    n_checks++;
    if ({bus.hsync, bus.burst_gate, bus.line_start, bus.burst_odd} !== 4'b0000)
      $display("FAIL reset_low_outputs got=%b exp=0000", {bus.hsync, bus.burst_gate, bus.line_start, bus.burst_odd});
    else n_pass++;
    n_checks++;
    if (bus.blank !== 1'b1) $display("FAIL reset_blank got=%b exp=1", bus.blank);
    else n_pass++;
    n_checks++;
    if (bus.vmode !== 2'd0 || bus.hstate !== 3'd0)
      $display("FAIL reset_state got vmode=%0d hstate=%0d exp 0/0", bus.vmode, bus.hstate);
    else n_pass++;
  endtask

  task automatic test_ntsc_line();
    int hs_first = -1, hs_last = -1, hs_cnt = 0;
    int bg_first = -1, bg_last = -1;
    int bl_first = -1, bl_cnt = 0, ls_cnt = 0;
    drive(1'b1, NTSC, 500, 99);
    drive(1'b1, NTSC, 500, 99);
    drive(1'b0, NTSC, 500, 99);
    for (int x = 0; x < 520; x++) begin
      drive(1'b0, NTSC, x, 100);
      if (bus.hsync) begin
        if (hs_first < 0) hs_first = x;
        hs_last = x;
        hs_cnt++;
      end
      if (bus.burst_gate) begin
        if (bg_first < 0) bg_first = x;
        bg_last = x;
      end
      if (!bus.blank) begin
        if (bl_first < 0) bl_first = x;
        bl_cnt++;
      end
      if (bus.line_start) ls_cnt++;
    end
    n_checks++;
    if (hs_first != 8 || hs_last != 44 || hs_cnt != 37)
      $display("FAIL ntsc_hsync_span got=%0d..%0d (%0d) exp=8..44 (37)", hs_first, hs_last, hs_cnt);
    else n_pass++;
    n_checks++;
    if (bg_first != 50 || bg_last != 70)
      $display("FAIL ntsc_burst_span got=%0d..%0d exp=50..70", bg_first, bg_last);
    else n_pass++;
    n_checks++;
    if (bl_first != 96 || bl_cnt != 424)
      $display("FAIL ntsc_unblank got first=%0d cnt=%0d exp 96/424", bl_first, bl_cnt);
    else n_pass++;
    n_checks++;
    if (ls_cnt != 1) $display("FAIL ntsc_line_start_count got=%0d exp=1", ls_cnt);
    else n_pass++;
  endtask

  task automatic test_jump();
    for (int x = 0; x <= 40; x++) drive(1'b0, NTSC, x, 101);
    drive(1'b0, NTSC, 60, 101);
    n_checks++;
    if (bus.hstate !== 3'd3) $display("FAIL jump_hstate got=%0d exp=3", bus.hstate);
    else n_pass++;
    n_checks++;
    if (bus.hsync !== 1'b0 || bus.burst_gate !== 1'b1)
      $display("FAIL jump_outputs got hsync=%b burst=%b exp 0/1", bus.hsync, bus.burst_gate);
    else n_pass++;
    drive(1'b0, NTSC, 500, 101);
  endtask

  task automatic test_burst_odd();
    logic odd_at_start;
    logic ls_first;
    int   ls_cnt;
    drive(1'b1, PAL, 500, 41);
    drive(1'b0, PAL, 500, 41);
    for (int y = 42; y <= 43; y++) begin
      ls_cnt = 0;
      odd_at_start = 1'bx;
      ls_first = 1'bx;
      for (int i = 0; i < 18; i++) begin
        drive(1'b0, PAL, xs[i], y);
        if (i == 0) begin
          odd_at_start = bus.burst_odd;
          ls_first     = bus.line_start;
        end
        if (bus.line_start) ls_cnt++;
      end
      n_checks++;
      if (odd_at_start !== ((y == 43) ? 1'b1 : 1'b0))
        $display("FAIL burst_odd_y%0d got=%b exp=%0d", y, odd_at_start, y % 2);
      else n_pass++;
      n_checks++;
      if (ls_first !== 1'b1 || ls_cnt != 1)
        $display("FAIL line_start_pulse_y%0d got first=%b cnt=%0d exp 1/1", y, ls_first, ls_cnt);
      else n_pass++;
    end
  endtask

  task automatic test_pal_frame();
    sweep_lines(PAL, 295, 315);
    for (int y = 301; y <= 309; y++) begin
      int ev;
      ev = (y >= 304 && y <= 306) ? 2 : 1;
      n_checks++;
      if (line_vm[y] != ev) $display("FAIL pal_vmode_y%0d got=%0d exp=%0d", y, line_vm[y], ev);
      else n_pass++;
      n_checks++;
      if (line_hs[y] || line_bg[y])
        $display("FAIL pal_no_sync_y%0d got hs=%b bg=%b exp 0/0", y, line_hs[y], line_bg[y]);
      else n_pass++;
    end
    n_checks++;
    if (!line_bg[300] || !line_bg[310] || line_vm[300] != 0 || line_vm[310] != 0)
      $display("FAIL pal_pre_post_burst got bg300=%b bg310=%b exp 1/1", line_bg[300], line_bg[310]);
    else n_pass++;
    n_checks++;
    if (!line_hs[311] || !line_hs[300])
      $display("FAIL pal_hsync_edges got hs300=%b hs311=%b exp 1/1", line_hs[300], line_hs[311]);
    else n_pass++;
  endtask

  task automatic test_reset_in_serr();
    sweep_lines(PAL, 298, 304);
    drive(1'b0, PAL, 0, 305);
    drive(1'b0, PAL, 5, 305);
    drive(1'b0, PAL, 30, 305);
    n_checks++;
    if (bus.vmode !== 2'd2) $display("FAIL serr_before_reset got=%0d exp=2", bus.vmode);
    else n_pass++;
    for (int i = 0; i < 3; i++) drive(1'b1, PAL, 30, 305);
    n_checks++;
    if ({bus.hsync, bus.blank, bus.burst_gate, bus.vmode, bus.hstate} !== {1'b0, 1'b1, 1'b0, 2'd0, 3'd0})
      $display("FAIL serr_reset_values got hs=%b bl=%b bg=%b vm=%0d h=%0d", bus.hsync, bus.blank,
               bus.burst_gate, bus.vmode, bus.hstate);
    else n_pass++;
    drive(1'b0, PAL, 40, 305);
    n_checks++;
    if (bus.hsync !== 1'b1) $display("FAIL serr_release_hsync got=%b exp=1", bus.hsync);
    else n_pass++;
    drive(1'b0, PAL, 60, 305);
    drive(1'b0, PAL, 500, 305);
    sweep_lines(PAL, 306, 315);
    n_checks++;
    if (line_vm[306] != 0 || !line_hs[306] || !line_bg[306])
      $display("FAIL serr_normal_line got vm=%0d hs=%b bg=%b exp 0/1/1", line_vm[306], line_hs[306], line_bg[306]);
    else n_pass++;
    sweep_lines(PAL, 298, 312);
    for (int y = 301; y <= 309; y++) begin
      int ev;
      ev = (y >= 304 && y <= 306) ? 2 : 1;
      n_checks++;
      if (line_vm[y] != ev || line_hs[y] || line_bg[y])
        $display("FAIL next_frame_y%0d got vm=%0d hs=%b bg=%b exp vm=%0d", y, line_vm[y], line_hs[y], line_bg[y], ev);
      else n_pass++;
    end
    n_checks++;
    if (!line_bg[300] || !line_bg[310])
      $display("FAIL next_frame_burst got bg300=%b bg310=%b exp 1/1", line_bg[300], line_bg[310]);
    else n_pass++;
  endtask

  task automatic test_chip_switch();
    logic hs7, hs8;
    int   hs_first = -1, hs_last = -1;
    drive(1'b1, NTSC, 500, 149);
    drive(1'b0, NTSC, 500, 149);
    for (int i = 0; i < 18; i++) drive(1'b0, (i > 4) ? PAL : NTSC, xs[i], 150);
    hs7 = 1'bx;
    hs8 = 1'bx;
    for (int i = 0; i < 18; i++) begin
      drive(1'b0, PAL, xs[i], 151);
      if (xs[i] == 7) hs7 = bus.hsync;
      if (xs[i] == 8) hs8 = bus.hsync;
    end
    n_checks++;
    if (hs7 !== 1'b0 || hs8 !== 1'b1)
      $display("FAIL chip_hold_ntsc got hs7=%b hs8=%b exp 0/1", hs7, hs8);
    else n_pass++;
    for (int x = 0; x <= 100; x++) begin
      drive(1'b0, PAL, x, 0);
      if (bus.hsync) begin
        if (hs_first < 0) hs_first = x;
        hs_last = x;
      end
    end
    n_checks++;
    if (hs_first != 7 || hs_last != 43)
      $display("FAIL chip_pal_hsync got=%0d..%0d exp=7..43", hs_first, hs_last);
    else n_pass++;
    drive(1'b0, PAL, 500, 0);
  endtask

  initial begin
    bus.chip     = 2'd0;
    bus.raster_x = 10'd0;
    bus.raster_y = 9'd0;
    test_reset();
    test_ntsc_line();
    test_jump();
    test_burst_odd();
    test_pal_frame();
    test_reset_in_serr();
    test_chip_switch();
    n_checks++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
